// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared types, defaults and lane arithmetic for the skew feeder
package sa_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FIN    = 2'd2
   } feed_state_t;

   localparam int DEF_DIM    = 8;
   localparam int DEF_DATA_W = 16;

   // Tile index a lane consumes at beat t; negative or >= DIM means the lane is idle.
   function automatic int lane_k(input int t, input int lane);
      return t - lane;
   endfunction

endpackage

// File: rtl/skew_bank.sv
// rtl/skew_bank.sv - one DIM x DIM operand bank with clear and per-lane skewed read
module skew_bank
   import sa_pkg::*;
#(
   parameter int DIM       = DEF_DIM,
   parameter int DATA_W    = DEF_DATA_W,
   parameter bit TRANSPOSE = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wr_en,
   input  logic                          clr,
   input  logic [$clog2(DIM)-1:0]        wr_row,
   input  logic [$clog2(DIM)-1:0]        wr_col,
   input  logic [DATA_W-1:0]             wr_data,
   input  logic [DIM*($clog2(DIM)+2)-1:0] rd_k,
   output logic [DIM*DATA_W-1:0]         rd_data,
   output logic [DIM-1:0]                rd_vld
);
   localparam int LW = $clog2(DIM);
   localparam int KW = LW + 2;
   localparam logic signed [KW-1:0] K_DIM = KW'(DIM);

   logic [DATA_W-1:0] mem [DIM][DIM];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
               mem[r][c] <= '0;
      end else if (clr) begin
         for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
               mem[r][c] <= '0;
      end else if (wr_en) begin
         mem[wr_row][wr_col] <= wr_data;
      end
   end

   for (genvar g = 0; g < DIM; g++) begin : g_lane
      logic signed [KW-1:0] k;
      logic                 in_range;
      logic [LW-1:0]        ki;
      logic [DATA_W-1:0]    word;

      assign k        = rd_k[g*KW +: KW];
      assign in_range = !k[KW-1] && (k < K_DIM);
      assign ki       = k[LW-1:0];

      // Row operand reads along its own row; column operand reads down its column.
      if (TRANSPOSE) begin : g_col
         assign word = mem[ki][g];
      end else begin : g_row
         assign word = mem[g][ki];
      end

      assign rd_data[g*DATA_W +: DATA_W] = in_range ? word : '0;
      assign rd_vld[g]                   = in_range;
   end

endmodule

// File: rtl/skew_feeder.sv
// rtl/skew_feeder.sv - streams row/column operand tiles into the array edges with diagonal skew
module skew_feeder
   import sa_pkg::*;
#(
   parameter int DIM    = DEF_DIM,
   parameter int DATA_W = DEF_DATA_W,
   parameter int AW     = 2*$clog2(DIM)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic                  wr_sel,
   input  logic [AW-1:0]         wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   output logic                  wr_err,
   input  logic                  clear,
   input  logic                  start,
   input  logic                  hold,
   output logic [DIM*DATA_W-1:0] r_out,
   output logic [DIM-1:0]        r_vld,
   output logic [DIM*DATA_W-1:0] c_out,
   output logic [DIM-1:0]        c_vld,
   output logic                  busy,
   output logic                  done
);
   localparam int LW = $clog2(DIM);
   localparam int KW = LW + 2;
   localparam int TW = LW + 1;
   localparam logic [TW-1:0] T_LAST = TW'(2*DIM - 2);

   feed_state_t           state;
   logic [TW-1:0]         t;
   logic [TW-1:0]         t_nxt;
   logic                  idle;
   logic                  wr_ok;
   logic                  clr_ok;
   logic [DIM*KW-1:0]     k_vec;
   logic [DIM*DATA_W-1:0] a_data;
   logic [DIM*DATA_W-1:0] b_data;
   logic [DIM-1:0]        a_vld;
   logic [DIM-1:0]        b_vld;

   assign idle   = (state == IDLE);
   assign wr_ok  = idle && wr_en && !start && !clear;
   assign clr_ok = idle && clear && !start;
   // Banks are read at the beat about to be registered, so outputs stay flop-driven.
   assign t_nxt  = (state == STREAM) ? t + TW'(1) : '0;

   for (genvar g = 0; g < DIM; g++) begin : g_k
      assign k_vec[g*KW +: KW] = KW'(lane_k(int'(t_nxt), g));
   end

   skew_bank #(.DIM(DIM), .DATA_W(DATA_W), .TRANSPOSE(1'b0)) u_bank_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_ok && !wr_sel),
      .clr     (clr_ok),
      .wr_row  (wr_addr[AW-1:LW]),
      .wr_col  (wr_addr[LW-1:0]),
      .wr_data (wr_data),
      .rd_k    (k_vec),
      .rd_data (a_data),
      .rd_vld  (a_vld)
   );

   skew_bank #(.DIM(DIM), .DATA_W(DATA_W), .TRANSPOSE(1'b1)) u_bank_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_ok && wr_sel),
      .clr     (clr_ok),
      .wr_row  (wr_addr[AW-1:LW]),
      .wr_col  (wr_addr[LW-1:0]),
      .wr_data (wr_data),
      .rd_k    (k_vec),
      .rd_data (b_data),
      .rd_vld  (b_vld)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         t      <= '0;
         r_out  <= '0;
         r_vld  <= '0;
         c_out  <= '0;
         c_vld  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         wr_err <= 1'b0;
      end else begin
         wr_err <= wr_en && (!idle || start);
         done   <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= STREAM;
                  t     <= '0;
                  busy  <= 1'b1;
                  r_out <= a_data;
                  r_vld <= a_vld;
                  c_out <= b_data;
                  c_vld <= b_vld;
               end
            end
            STREAM: begin
               if (!hold) begin
                  if (t == T_LAST) begin
                     state <= FIN;
                     t     <= '0;
                     done  <= 1'b1;
                     r_out <= '0;
                     r_vld <= '0;
                     c_out <= '0;
                     c_vld <= '0;
                  end else begin
                     t     <= t_nxt;
                     r_out <= a_data;
                     r_vld <= a_vld;
                     c_out <= b_data;
                     c_vld <= b_vld;
                  end
               end
            end
            FIN: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_skew_feeder.sv
// tb/tb_skew_feeder.sv - self-checking bench for skew_feeder at DIM=4, DATA_W=16
module tb_skew_feeder;
   localparam int DIM = 4;
   localparam int DW  = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic          wr_sel = 1'b0;
   logic [3:0]    wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_err;
   logic          clear = 1'b0;
   logic          start = 1'b0;
   logic          hold = 1'b0;
   logic [63:0]   r_out;
   logic [3:0]    r_vld;
   logic [63:0]   c_out;
   logic [3:0]    c_vld;
   logic          busy;
   logic          done;

   int checks = 0;
   int failures = 0;
   logic [DW-1:0] ma [DIM][DIM];
   logic [DW-1:0] mb [DIM][DIM];

   skew_feeder #(.DIM(DIM), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_err(wr_err), .clear(clear), .start(start), .hold(hold),
      .r_out(r_out), .r_vld(r_vld), .c_out(c_out), .c_vld(c_vld), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_zero;
      for (int i = 0; i < DIM; i++)
         for (int j = 0; j < DIM; j++) begin
            ma[i][j] = '0;
            mb[i][j] = '0;
         end
   endtask

   task automatic wr(input bit sel, input int row, input int col, input logic [DW-1:0] d);
      wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(row*DIM + col); wr_data = d;
      step;
      wr_en = 1'b0;
      if (sel) mb[row][col] = d; else ma[row][col] = d;
      chk("wr_err_idle", wr_err, 0);
   endtask

   task automatic load_pattern;
      for (int i = 0; i < DIM; i++)
         for (int k = 0; k < DIM; k++) begin
            wr(0, i, k, 16'(16*i + k));
            wr(1, i, k, 16'(100 + 16*i + k));
         end
   endtask

   task automatic check_beat(input int t);
      logic [63:0] er, ec;
      logic [3:0]  ev;
      er = '0; ec = '0; ev = '0;
      for (int i = 0; i < DIM; i++) begin
         int k;
         k = t - i;
         if (k >= 0 && k < DIM) begin
            er[i*DW +: DW] = ma[i][k];
            ec[i*DW +: DW] = mb[k][i];
            ev[i] = 1'b1;
         end
      end
      chk("r_out", r_out, er);
      chk("r_vld", r_vld, ev);
      chk("c_out", c_out, ec);
      chk("c_vld", c_vld, ev);
      chk("busy_stream", busy, 1);
      chk("done_stream", done, 0);
   endtask

   task automatic check_fin;
      chk("done_fin", done, 1);
      chk("busy_fin", busy, 1);
      chk("r_vld_fin", r_vld, 0);
      chk("c_vld_fin", c_vld, 0);
      chk("r_out_fin", r_out, 0);
      chk("c_out_fin", c_out, 0);
      step;
      chk("done_pulse", done, 0);
      chk("busy_idle", busy, 0);
   endtask

   task automatic run_stream(input int hold_beat, input int hold_len, input bit spot);
      start = 1'b1;
      step;
      start = 1'b0;
      for (int t = 0; t < 2*DIM-1; t++) begin
         check_beat(t);
         if (spot && t == 0) begin
            chk("b0_rvld", r_vld, 4'b0001);
            chk("b0_cvld", c_vld, 4'b0001);
            chk("b0_r0", r_out[15:0], 16'h0000);
            chk("b0_c0", c_out[15:0], 16'd100);
         end
         if (spot && t == 3) begin
            chk("b3_rvld", r_vld, 4'hF);
            chk("b3_r3", r_out[63:48], 16'h0030);
         end
         if (spot && t == 6) begin
            chk("b6_rvld", r_vld, 4'b1000);
            chk("b6_r3", r_out[63:48], 16'h0033);
            chk("b6_c3", c_out[63:48], 16'd151);
         end
         if (t == hold_beat)
            for (int h = 0; h < hold_len; h++) begin
               hold = 1'b1;
               step;
               check_beat(t);
            end
         hold = 1'b0;
         step;
      end
      check_fin;
   endtask

   task automatic wait_done;
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         step;
         if (done) seen = 1'b1;
      end
      chk("done_seen", seen, 1);
      step;
   endtask

   initial begin
      model_zero;
      step;
      step;
      chk("rst_r_out", r_out, 0);
      chk("rst_r_vld", r_vld, 0);
      chk("rst_c_out", c_out, 0);
      chk("rst_c_vld", c_vld, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_wr_err", wr_err, 0);
      rst_n = 1'b1;
      step;

      load_pattern;
      run_stream(-1, 0, 1);
      run_stream(2, 3, 0);

      start = 1'b1;
      step;
      start = 1'b0;
      step;
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 16'hFFFF;
      step;
      wr_en = 1'b0;
      chk("wr_err_stream", wr_err, 1);
      check_beat(2);
      step;
      chk("wr_err_once", wr_err, 0);
      wait_done;
      run_stream(-1, 0, 1);

      start = 1'b1; wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'd0; wr_data = 16'hBEEF;
      step;
      start = 1'b0; wr_en = 1'b0;
      chk("wr_err_start", wr_err, 1);
      check_beat(0);
      step;
      chk("wr_err_start_once", wr_err, 0);
      wait_done;
      run_stream(-1, 0, 1);

      clear = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd5; wr_data = 16'h1234;
      step;
      clear = 1'b0; wr_en = 1'b0;
      chk("wr_err_clear", wr_err, 0);
      model_zero;
      run_stream(-1, 0, 0);

      for (int it = 0; it < 3; it++) begin
         for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
               wr(0, i, j, 16'($urandom));
               wr(1, i, j, 16'($urandom));
            end
         run_stream(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 0);
      end

      load_pattern;
      start = 1'b1;
      step;
      start = 1'b0;
      for (int t = 0; t < 4; t++) step;
      check_beat(4);
      rst_n = 1'b0;
      #1;
      chk("arst_r_out", r_out, 0);
      chk("arst_r_vld", r_vld, 0);
      chk("arst_c_out", c_out, 0);
      chk("arst_c_vld", c_vld, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      step;
      rst_n = 1'b1;
      model_zero;
      for (int n = 0; n < 10; n++) begin
         step;
         chk("no_done_after_rst", done, 0);
      end
      run_stream(-1, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
